// File: rtl/bp_fe_nonsynth_pc_gen_replayer.sv
// Replays a recorded pc_gen trace into the frontend: each record drives an IF0 source
// strobe and is checked against the live IF2 fetch PC/validity three stages later.
module bp_fe_nonsynth_pc_gen_replayer #(
    parameter int vaddr_width_p = 39,
    parameter int cnt_width_p   = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_li,
    input  logic                     freeze_i,
    input  logic                     start_i,
    input  logic                     rec_v_i,
    output logic                     rec_ready_o,
    input  logic                     rec_last_i,
    input  logic [2:0]               rec_src_i,
    input  logic                     rec_fetch_v_i,
    input  logic [vaddr_width_p-1:0] rec_pc_i,
    output logic                     src_redirect_o,
    output logic                     src_override_ras_o,
    output logic                     src_override_branch_o,
    output logic                     src_btb_taken_branch_o,
    input  logic                     fetch_v_i,
    input  logic [vaddr_width_p-1:0] fetch_pc_i,
    output logic                     mismatch_o,
    output logic [cnt_width_p-1:0]   mismatch_cnt_o,
    output logic [cnt_width_p-1:0]   underflow_cnt_o,
    output logic [cnt_width_p-1:0]   cycle_cnt_o,
    output logic [vaddr_width_p-1:0] first_bad_pc_o,
    output logic [cnt_width_p-1:0]   first_bad_cycle_o,
    output logic                     error_o,
    output logic                     done_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic                     r_vld_p1, r_vld_p2, r_vld_p3;
    logic                     r_fv_p1, r_fv_p2, r_fv_p3;
    logic [2:0]               r_src_p1;
    logic [vaddr_width_p-1:0] r_pc_p1, r_pc_p2, r_pc_p3;
    logic                     r_mismatch;
    logic                     r_error;
    logic [cnt_width_p-1:0]   r_mm_cnt, r_uf_cnt, r_cyc_cnt, r_first_cyc;
    logic [vaddr_width_p-1:0] r_first_pc;
    logic                     w_accept, w_underflow, w_counting, w_mismatch;

    function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] x);
        return (&x) ? x : x + cnt_width_p'(1);
    endfunction

    assign w_accept    = rec_v_i & rec_ready_o;
    assign w_underflow = (r_state == ST_RUN) & ~freeze_i & ~rec_v_i;
    assign w_counting  = ((r_state == ST_RUN) | (r_state == ST_DRAIN)) & ~freeze_i;
    assign w_mismatch  = r_vld_p3 & ~freeze_i &
                         ((fetch_v_i != r_fv_p3) | (r_fv_p3 & (fetch_pc_i != r_pc_p3)));

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li)
            r_state <= ST_IDLE;
        else if (!freeze_i)
            r_state <= w_state_nxt;
    end

    // DRAIN ends on the edge that checks the last entry in S3, so S3 is not waited on.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start_i) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_accept && rec_last_i) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!r_vld_p1 && !r_vld_p2) w_state_nxt = ST_DONE;
            default:  w_state_nxt = r_state;
        endcase
    end

    always_comb begin
        rec_ready_o            = (r_state == ST_RUN) & ~freeze_i;
        done_o                 = (r_state == ST_DONE);
        src_redirect_o         = 1'b0;
        src_override_ras_o     = 1'b0;
        src_override_branch_o  = 1'b0;
        src_btb_taken_branch_o = 1'b0;
        if (r_vld_p1) begin
            case (r_src_p1)
                3'd1:    src_redirect_o         = 1'b1;
                3'd2:    src_override_ras_o     = 1'b1;
                3'd3:    src_override_branch_o  = 1'b1;
                3'd4:    src_btb_taken_branch_o = 1'b1;
                default: ;
            endcase
        end
    end

    // S1 -> S2 -> S3 valid chain
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else if (!freeze_i) begin
            r_vld_p1 <= w_accept;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!freeze_i) begin
            r_src_p1 <= rec_src_i;
            r_fv_p1  <= rec_fetch_v_i;
            r_pc_p1  <= rec_pc_i;
            r_fv_p2  <= r_fv_p1;
            r_pc_p2  <= r_pc_p1;
            r_fv_p3  <= r_fv_p2;
            r_pc_p3  <= r_pc_p2;
        end
    end

    // S3 check results and statistics
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            r_mismatch  <= 1'b0;
            r_error     <= 1'b0;
            r_mm_cnt    <= '0;
            r_uf_cnt    <= '0;
            r_cyc_cnt   <= '0;
            r_first_pc  <= '0;
            r_first_cyc <= '0;
        end else begin
            r_mismatch <= w_mismatch;
            if (w_accept && (rec_src_i[2:1] == 2'b11))
                r_error <= 1'b1;
            if (w_underflow)
                r_uf_cnt <= sat_inc(r_uf_cnt);
            if (w_counting)
                r_cyc_cnt <= r_cyc_cnt + cnt_width_p'(1);
            if (w_mismatch) begin
                r_mm_cnt <= sat_inc(r_mm_cnt);
                if (r_mm_cnt == '0) begin
                    r_first_pc  <= fetch_pc_i;
                    r_first_cyc <= r_cyc_cnt;
                end
            end
        end
    end

    assign mismatch_o        = r_mismatch;
    assign mismatch_cnt_o    = r_mm_cnt;
    assign underflow_cnt_o   = r_uf_cnt;
    assign cycle_cnt_o       = r_cyc_cnt;
    assign first_bad_pc_o    = r_first_pc;
    assign first_bad_cycle_o = r_first_cyc;
    assign error_o           = r_error;

endmodule

// File: tb/tb_bp_fe_nonsynth_pc_gen_replayer.sv
// Bench for bp_fe_nonsynth_pc_gen_replayer: directed trace scenarios plus a randomized
// stream checked against a tick-indexed record map kept in the bench.
module tb_bp_fe_nonsynth_pc_gen_replayer;
    localparam int VA_W = 39;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              clk = 1'b0;
    logic              reset_li = 1'b0;
    logic              freeze_i = 1'b0;
    logic              start_i = 1'b0;
    logic              rec_v_i = 1'b0;
    logic              rec_last_i = 1'b0;
    logic [2:0]        rec_src_i = 3'd0;
    logic              rec_fetch_v_i = 1'b0;
    logic [VA_W-1:0]   rec_pc_i = '0;
    logic              fetch_v_i = 1'b0;
    logic [VA_W-1:0]   fetch_pc_i = '0;
    logic              rec_ready_o;
    logic              src_redirect_o, src_override_ras_o, src_override_branch_o, src_btb_taken_branch_o;
    logic              mismatch_o;
    logic [CNT_W-1:0]  mismatch_cnt_o, underflow_cnt_o, cycle_cnt_o, first_bad_cycle_o;
    logic [VA_W-1:0]   first_bad_pc_o;
    logic              error_o, done_o;
    logic [3:0]        strb;

    always #5 clk = ~clk;

    bp_fe_nonsynth_pc_gen_replayer #(.vaddr_width_p(VA_W), .cnt_width_p(CNT_W)) dut (
        .clk_i(clk), .reset_li(reset_li), .freeze_i(freeze_i), .start_i(start_i),
        .rec_v_i(rec_v_i), .rec_ready_o(rec_ready_o), .rec_last_i(rec_last_i),
        .rec_src_i(rec_src_i), .rec_fetch_v_i(rec_fetch_v_i), .rec_pc_i(rec_pc_i),
        .src_redirect_o(src_redirect_o), .src_override_ras_o(src_override_ras_o),
        .src_override_branch_o(src_override_branch_o),
        .src_btb_taken_branch_o(src_btb_taken_branch_o),
        .fetch_v_i(fetch_v_i), .fetch_pc_i(fetch_pc_i), .mismatch_o(mismatch_o),
        .mismatch_cnt_o(mismatch_cnt_o), .underflow_cnt_o(underflow_cnt_o),
        .cycle_cnt_o(cycle_cnt_o), .first_bad_pc_o(first_bad_pc_o),
        .first_bad_cycle_o(first_bad_cycle_o), .error_o(error_o), .done_o(done_o)
    );

    assign strb = {src_redirect_o, src_override_ras_o, src_override_branch_o, src_btb_taken_branch_o};

    // Reference model: records keyed by the unfrozen-edge number that accepted them.
    typedef struct packed { logic fv; logic [2:0] src; logic [VA_W-1:0] pc; } rec_t;
    rec_t             m_rec [int];
    int               m_tick, m_st, m_drain;
    logic [CNT_W-1:0] m_mm_cnt, m_uf_cnt, m_cyc, m_first_cyc;
    logic [VA_W-1:0]  m_first_pc;
    logic             m_mm, m_err, m_seen_bad;
    int               n_chk = 0;
    int               n_pass = 0;

    function automatic logic [VA_W-1:0] rand_pc();
        return VA_W'({$urandom(), $urandom()});
    endfunction

    function automatic logic [3:0] exp_strb();
        logic [3:0] s = 4'b0000;
        if (m_rec.exists(m_tick)) begin
            case (m_rec[m_tick].src)
                3'd1:    s = 4'b1000;
                3'd2:    s = 4'b0100;
                3'd3:    s = 4'b0010;
                3'd4:    s = 4'b0001;
                default: s = 4'b0000;
            endcase
        end
        return s;
    endfunction

    task automatic model_reset();
        m_rec.delete();
        m_tick = 0; m_st = 0; m_drain = 0;
        m_mm_cnt = '0; m_uf_cnt = '0; m_cyc = '0; m_first_cyc = '0;
        m_first_pc = '0; m_mm = 1'b0; m_err = 1'b0; m_seen_bad = 1'b0;
    endtask

    // One clock: drive inputs, take the edge, advance the model, sample 1 time unit later.
    // lmode 0 mirrors the record due for checking on the live side; lmode 1 drives lfv/lpc.
    task automatic cyc(input bit v, input bit last, input logic [2:0] src, input bit fv,
                       input logic [VA_W-1:0] pc, input bit frz, input bit st,
                       input bit lmode, input bit lfv, input logic [VA_W-1:0] lpc);
        rec_t r;
        bit   acc;
        rec_v_i = v; rec_last_i = last; rec_src_i = src; rec_fetch_v_i = fv; rec_pc_i = pc;
        freeze_i = frz; start_i = st;
        if (lmode) begin
            fetch_v_i = lfv; fetch_pc_i = lpc;
        end else if (m_rec.exists(m_tick - 2)) begin
            fetch_v_i = m_rec[m_tick - 2].fv; fetch_pc_i = m_rec[m_tick - 2].pc;
        end else begin
            fetch_v_i = 1'($urandom()); fetch_pc_i = rand_pc();
        end
        @(posedge clk);
        m_mm = 1'b0;
        if (!frz) begin
            m_tick++;
            if (m_rec.exists(m_tick - 3)) begin
                r = m_rec[m_tick - 3];
                if ((fetch_v_i !== r.fv) || (r.fv && (fetch_pc_i !== r.pc))) begin
                    m_mm = 1'b1;
                    if (!m_seen_bad) begin
                        m_seen_bad = 1'b1; m_first_pc = fetch_pc_i; m_first_cyc = m_cyc;
                    end
                    if (m_mm_cnt != CNT_MAX) m_mm_cnt++;
                end
            end
            acc = (m_st == 1) && v;
            if ((m_st == 1) && !v && (m_uf_cnt != CNT_MAX)) m_uf_cnt++;
            if ((m_st == 1) || (m_st == 2)) m_cyc++;
            if (acc) begin
                r.fv = fv; r.src = src; r.pc = pc;
                m_rec[m_tick] = r;
                if (src >= 3'd6) m_err = 1'b1;
            end
            case (m_st)
                0: if (st) m_st = 1;
                1: if (acc && last) begin m_st = 2; m_drain = 0; end
                2: begin m_drain++; if (m_drain == 3) m_st = 3; end
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic go();   cyc(1'b0, 1'b0, 3'd0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0); endtask
    task automatic gap();  cyc(1'b0, 1'b0, 3'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0); endtask
    task automatic rec(input bit last, input logic [2:0] src, input bit fv, input logic [VA_W-1:0] pc);
        cyc(1'b1, last, src, fv, pc, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask
    task automatic live(input bit lfv, input logic [VA_W-1:0] lpc);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, '0, 1'b0, 1'b0, 1'b1, lfv, lpc);
    endtask

    task automatic do_reset();
        reset_li = 1'b0; freeze_i = 1'b0; start_i = 1'b0; rec_v_i = 1'b0; rec_last_i = 1'b0;
        @(posedge clk);
        #1 reset_li = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_li = 1'b0; start_i = 1'b1; rec_v_i = 1'b1; rec_src_i = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (rec_ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", rec_ready_o); else n_pass++;
        n_chk++; if (strb !== 4'b0000) $display("FAIL reset_strobes: got %b want 0000", strb); else n_pass++;
        n_chk++; if (mismatch_o !== 1'b0) $display("FAIL reset_mismatch: got %b want 0", mismatch_o); else n_pass++;
        n_chk++; if (mismatch_cnt_o !== '0) $display("FAIL reset_mm_cnt: got %0d want 0", mismatch_cnt_o); else n_pass++;
        n_chk++; if (underflow_cnt_o !== '0) $display("FAIL reset_uf_cnt: got %0d want 0", underflow_cnt_o); else n_pass++;
        n_chk++; if (cycle_cnt_o !== '0) $display("FAIL reset_cyc_cnt: got %0d want 0", cycle_cnt_o); else n_pass++;
        n_chk++; if (first_bad_pc_o !== '0) $display("FAIL reset_first_pc: got %h want 0", first_bad_pc_o); else n_pass++;
        n_chk++; if (first_bad_cycle_o !== '0) $display("FAIL reset_first_cyc: got %0d want 0", first_bad_cycle_o); else n_pass++;
        n_chk++; if (error_o !== 1'b0) $display("FAIL reset_error: got %b want 0", error_o); else n_pass++;
        n_chk++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else n_pass++;
        start_i = 1'b0; rec_v_i = 1'b0; rec_src_i = 3'd0;
        reset_li = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        logic [2:0]      srcs [4] = '{3'd1, 3'd5, 3'd4, 3'd2};
        logic [VA_W-1:0] pcs  [4] = '{39'h80000954, 39'h80000958, 39'h800007f8, 39'h800007fc};
        logic [3:0]      want [4] = '{4'b1000, 4'b0000, 4'b0001, 4'b0100};
        do_reset();
        go();
        n_chk++; if (rec_ready_o !== 1'b1) $display("FAIL stream_ready: got %b want 1", rec_ready_o); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            rec(i == 3, srcs[i], 1'b1, pcs[i]);
            n_chk++; if (strb !== want[i]) $display("FAIL stream_strobe%0d: got %b want %b", i, strb, want[i]); else n_pass++;
        end
        n_chk++; if (rec_ready_o !== 1'b0) $display("FAIL stream_ready_drain: got %b want 0", rec_ready_o); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            gap();
            n_chk++; if (mismatch_o !== 1'b0) $display("FAIL stream_mismatch%0d: got %b want 0", i, mismatch_o); else n_pass++;
            n_chk++; if (done_o !== (i == 2)) $display("FAIL stream_done%0d: got %b want %b", i, done_o, i == 2); else n_pass++;
        end
        n_chk++; if (mismatch_cnt_o !== 8'd0) $display("FAIL stream_mm_cnt: got %0d want 0", mismatch_cnt_o); else n_pass++;
        n_chk++; if (cycle_cnt_o !== 8'd7) $display("FAIL stream_cyc_cnt: got %0d want 7", cycle_cnt_o); else n_pass++;
    endtask

    task automatic test_mismatch();
        do_reset();
        go();
        rec(1'b0, 3'd5, 1'b1, 39'h80000710);
        gap();
        gap();
        live(1'b1, 39'h80000714);
        n_chk++; if (mismatch_o !== 1'b1) $display("FAIL mm_pulse: got %b want 1", mismatch_o); else n_pass++;
        n_chk++; if (mismatch_cnt_o !== 8'd1) $display("FAIL mm_cnt: got %0d want 1", mismatch_cnt_o); else n_pass++;
        n_chk++; if (first_bad_pc_o !== 39'h80000714) $display("FAIL mm_first_pc: got %h want 80000714", first_bad_pc_o); else n_pass++;
        n_chk++; if (first_bad_cycle_o !== 8'd3) $display("FAIL mm_first_cyc: got %0d want 3", first_bad_cycle_o); else n_pass++;
        gap();
        n_chk++; if (mismatch_o !== 1'b0) $display("FAIL mm_single_pulse: got %b want 0", mismatch_o); else n_pass++;
        n_chk++; if (mismatch_cnt_o !== 8'd1) $display("FAIL mm_cnt_hold: got %0d want 1", mismatch_cnt_o); else n_pass++;
    endtask

    task automatic test_fetch_v0();
        do_reset();
        go();
        rec(1'b0, 3'd5, 1'b0, 39'h80000998);
        rec(1'b0, 3'd1, 1'b1, 39'h80000a00);
        gap();
        live(1'b0, 39'h12345678);
        n_chk++; if (mismatch_o !== 1'b0) $display("FAIL fv0_no_pc_cmp: got %b want 0", mismatch_o); else n_pass++;
        live(1'b0, 39'h80000a00);
        n_chk++; if (mismatch_o !== 1'b1) $display("FAIL fv_differs: got %b want 1", mismatch_o); else n_pass++;
        n_chk++; if (first_bad_pc_o !== 39'h80000a00) $display("FAIL fv_first_pc: got %h want 80000a00", first_bad_pc_o); else n_pass++;
    endtask

    task automatic test_underflow();
        do_reset();
        go();
        rec(1'b0, 3'd4, 1'b1, 39'h80000100);
        gap();
        n_chk++; if (strb !== 4'b0000) $display("FAIL uf_strobe0: got %b want 0000", strb); else n_pass++;
        gap();
        n_chk++; if (strb !== 4'b0000) $display("FAIL uf_strobe1: got %b want 0000", strb); else n_pass++;
        rec(1'b1, 3'd2, 1'b1, 39'h80000200);
        n_chk++; if (underflow_cnt_o !== 8'd2) $display("FAIL uf_cnt: got %0d want 2", underflow_cnt_o); else n_pass++;
        n_chk++; if (mismatch_o !== 1'b0) $display("FAIL uf_first_check: got %b want 0", mismatch_o); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            live(1'b1, rand_pc());
            n_chk++; if (mismatch_o !== 1'b0) $display("FAIL uf_no_check%0d: got %b want 0", i, mismatch_o); else n_pass++;
        end
        gap();
        n_chk++; if (mismatch_o !== 1'b0) $display("FAIL uf_last_check: got %b want 0", mismatch_o); else n_pass++;
        n_chk++; if (underflow_cnt_o !== 8'd2) $display("FAIL uf_cnt_drain: got %0d want 2", underflow_cnt_o); else n_pass++;
    endtask

    task automatic test_freeze();
        logic [VA_W-1:0] pa = 39'h80000300;
        do_reset();
        go();
        rec(1'b0, 3'd3, 1'b1, pa);
        rec(1'b0, 3'd1, 1'b1, 39'h80000304);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 3'd2, 1'b1, rand_pc(), 1'b1, 1'b0, 1'b1, 1'b1, rand_pc());
            n_chk++; if (rec_ready_o !== 1'b0) $display("FAIL frz_ready%0d: got %b want 0", i, rec_ready_o); else n_pass++;
            n_chk++; if (strb !== 4'b1000) $display("FAIL frz_strobe%0d: got %b want 1000", i, strb); else n_pass++;
            n_chk++; if (cycle_cnt_o !== 8'd2) $display("FAIL frz_cyc%0d: got %0d want 2", i, cycle_cnt_o); else n_pass++;
            n_chk++; if (underflow_cnt_o !== 8'd0) $display("FAIL frz_uf%0d: got %0d want 0", i, underflow_cnt_o); else n_pass++;
            n_chk++; if (mismatch_o !== 1'b0) $display("FAIL frz_mm%0d: got %b want 0", i, mismatch_o); else n_pass++;
        end
        rec(1'b1, 3'd4, 1'b1, 39'h80000308);
        n_chk++; if (strb !== 4'b0001) $display("FAIL frz_resume_strobe: got %b want 0001", strb); else n_pass++;
        n_chk++; if (mismatch_o !== 1'b0) $display("FAIL frz_resume_mm: got %b want 0", mismatch_o); else n_pass++;
        live(1'b1, pa ^ 39'd1);
        n_chk++; if (mismatch_o !== 1'b1) $display("FAIL frz_align: got %b want 1", mismatch_o); else n_pass++;
        n_chk++; if (first_bad_pc_o !== (pa ^ 39'd1)) $display("FAIL frz_first_pc: got %h want %h", first_bad_pc_o, pa ^ 39'd1); else n_pass++;
    endtask

    task automatic test_error_reset();
        logic [VA_W-1:0] pe = 39'h80000500;
        do_reset();
        go();
        rec(1'b0, 3'd7, 1'b1, pe);
        n_chk++; if (error_o !== 1'b1) $display("FAIL err_set: got %b want 1", error_o); else n_pass++;
        n_chk++; if (strb !== 4'b0000) $display("FAIL err_strobe: got %b want 0000", strb); else n_pass++;
        rec(1'b0, 3'd5, 1'b1, 39'h80000504);
        gap();
        live(1'b1, pe + 39'd4);
        n_chk++; if (mismatch_o !== 1'b1) $display("FAIL err_rec_checked: got %b want 1", mismatch_o); else n_pass++;
        gap();
        n_chk++; if (error_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", error_o); else n_pass++;
        #2 reset_li = 1'b0;
        #1;
        n_chk++; if (error_o !== 1'b0) $display("FAIL areset_error: got %b want 0", error_o); else n_pass++;
        n_chk++; if (rec_ready_o !== 1'b0) $display("FAIL areset_ready: got %b want 0", rec_ready_o); else n_pass++;
        n_chk++; if (strb !== 4'b0000) $display("FAIL areset_strobes: got %b want 0000", strb); else n_pass++;
        n_chk++; if (mismatch_cnt_o !== '0) $display("FAIL areset_mm_cnt: got %0d want 0", mismatch_cnt_o); else n_pass++;
        n_chk++; if (cycle_cnt_o !== '0) $display("FAIL areset_cyc: got %0d want 0", cycle_cnt_o); else n_pass++;
        n_chk++; if (first_bad_pc_o !== '0) $display("FAIL areset_first_pc: got %h want 0", first_bad_pc_o); else n_pass++;
        @(posedge clk);
        #1 reset_li = 1'b1;
        model_reset();
    endtask

    task automatic test_saturation();
        do_reset();
        go();
        repeat (270) gap();
        n_chk++; if (underflow_cnt_o !== CNT_MAX) $display("FAIL sat_uf: got %0d want %0d", underflow_cnt_o, CNT_MAX); else n_pass++;
        n_chk++; if (cycle_cnt_o !== 8'd14) $display("FAIL wrap_cyc: got %0d want 14", cycle_cnt_o); else n_pass++;
        repeat (270) cyc(1'b1, 1'b0, 3'd5, 1'b1, rand_pc(), 1'b0, 1'b0, 1'b1, 1'b0, rand_pc());
        n_chk++; if (mismatch_cnt_o !== CNT_MAX) $display("FAIL sat_mm: got %0d want %0d", mismatch_cnt_o, CNT_MAX); else n_pass++;
        n_chk++; if (mismatch_o !== 1'b1) $display("FAIL sat_mm_pulse: got %b want 1", mismatch_o); else n_pass++;
        n_chk++; if (first_bad_cycle_o !== 8'd17) $display("FAIL sat_first_cyc: got %0d want 17", first_bad_cycle_o); else n_pass++;
        n_chk++; if (underflow_cnt_o !== CNT_MAX) $display("FAIL sat_uf_hold: got %0d want %0d", underflow_cnt_o, CNT_MAX); else n_pass++;
    endtask

    task automatic test_random();
        bit v, frz, lmode;
        do_reset();
        go();
        for (int i = 0; i < 400; i++) begin
            v     = ($urandom_range(0, 9) < 8);
            frz   = ($urandom_range(0, 9) == 0);
            lmode = ($urandom_range(0, 3) == 0);
            cyc(v, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rand_pc(), frz, 1'b0,
                lmode, 1'($urandom_range(0, 1)), rand_pc());
            n_chk++; if (strb !== exp_strb()) $display("FAIL rnd_strobe@%0d: got %b want %b", i, strb, exp_strb()); else n_pass++;
            n_chk++; if (rec_ready_o !== ((m_st == 1) && !frz)) $display("FAIL rnd_ready@%0d: got %b want %b", i, rec_ready_o, (m_st == 1) && !frz); else n_pass++;
            if (!frz) begin
                n_chk++; if (mismatch_o !== m_mm) $display("FAIL rnd_mm@%0d: got %b want %b", i, mismatch_o, m_mm); else n_pass++;
            end
            n_chk++; if (mismatch_cnt_o !== m_mm_cnt) $display("FAIL rnd_mm_cnt@%0d: got %0d want %0d", i, mismatch_cnt_o, m_mm_cnt); else n_pass++;
            n_chk++; if (underflow_cnt_o !== m_uf_cnt) $display("FAIL rnd_uf@%0d: got %0d want %0d", i, underflow_cnt_o, m_uf_cnt); else n_pass++;
            n_chk++; if (cycle_cnt_o !== m_cyc) $display("FAIL rnd_cyc@%0d: got %0d want %0d", i, cycle_cnt_o, m_cyc); else n_pass++;
            n_chk++; if (error_o !== m_err) $display("FAIL rnd_err@%0d: got %b want %b", i, error_o, m_err); else n_pass++;
            n_chk++; if (first_bad_pc_o !== m_first_pc) $display("FAIL rnd_first_pc@%0d: got %h want %h", i, first_bad_pc_o, m_first_pc); else n_pass++;
            n_chk++; if (first_bad_cycle_o !== m_first_cyc) $display("FAIL rnd_first_cyc@%0d: got %0d want %0d", i, first_bad_cycle_o, m_first_cyc); else n_pass++;
        end
        rec(1'b1, 3'd1, 1'b1, rand_pc());
        for (int i = 0; i < 3; i++) begin
            gap();
            n_chk++; if (done_o !== (m_st == 3)) $display("FAIL rnd_done%0d: got %b want %b", i, done_o, m_st == 3); else n_pass++;
            n_chk++; if (mismatch_cnt_o !== m_mm_cnt) $display("FAIL rnd_drain_mm%0d: got %0d want %0d", i, mismatch_cnt_o, m_mm_cnt); else n_pass++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_mismatch();
        test_fetch_v0();
        test_underflow();
        test_freeze();
        test_error_reset();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bp_fe_nonsynth_pc_gen_replayer.md
# bp_fe_nonsynth_pc_gen_replayer

Replays a recorded pc_gen fetch trace into the frontend and checks it. Trace records arrive on a valid/ready stream, one per cycle. Each record's IF0 source strobe is driven one cycle after acceptance. Its IF2 fetch PC and validity are checked against the live pc_gen outputs two cycles after that strobe. The block sits in the FE testbench beside pc_gen and counts mismatches, bubbles and illegal records for regression diffing.

## Interface
- vaddr_width_p, 39: width of fetch PC.
- cnt_width_p, 16: width of the mismatch, underflow and cycle counters.
- clk_i  in  1  clock, all state on posedge.
- reset_li  in  1  reset, asynchronous, active-low.
- freeze_i  in  1  holds all state; rec_ready_o forced low.
- start_i  in  1  one-cycle pulse, leaves IDLE.
- rec_v_i  in  1  record valid.
- rec_ready_o  out  1  record accepted when rec_v_i & rec_ready_o.
- rec_last_i  in  1  marks the final record; qualified by the handshake.
- rec_src_i  in  3  PC source: 0 undefined, 1 redirect, 2 override_ras, 3 override_branch, 4 btb_taken_branch, 5 last_fetch_plus_four; 6 and 7 are illegal.
- rec_fetch_v_i  in  1  expected IF2 validity.
- rec_pc_i  in  vaddr_width_p  expected IF2 PC.
- src_redirect_o, src_override_ras_o, src_override_branch_o, src_btb_taken_branch_o  out  1 each  IF0 strobes, at most one high.
- fetch_v_i  in  1  live IF2 validity.
- fetch_pc_i  in  vaddr_width_p  live IF2 PC.
- mismatch_o  out  1  single-cycle pulse on a failed check.
- mismatch_cnt_o  out  cnt_width_p  saturating count of failed checks.
- underflow_cnt_o  out  cnt_width_p  saturating count of RUN cycles with no record.
- cycle_cnt_o  out  cnt_width_p  wrapping count of RUN and DRAIN cycles.
- first_bad_pc_o  out  vaddr_width_p  live PC at the first mismatch.
- first_bad_cycle_o  out  cnt_width_p  cycle_cnt_o value at the first mismatch.
- error_o  out  1  sticky; set when an illegal rec_src_i is accepted.
- done_o  out  1  high in DONE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start_i.
  - RUN -> DRAIN when a record with rec_last_i is accepted.
  - DRAIN -> DONE when the pipeline holds no valid entries; this takes 3 cycles after entering DRAIN.
  - DONE is held until reset.
- rec_ready_o = (state==RUN) & ~freeze_i. It is combinational and does not depend on rec_v_i.
- Pipeline has three registered stages, S1, S2 and S3. Each stage holds {v, chk_fetch_v, pc}; S1 also holds src.
  - On acceptance, the record loads into S1 with v=1.
  - On a RUN cycle with no record (underflow), S1 loads with v=0 and underflow_cnt increments.
  - The pipeline advances every cycle unless freeze_i is high. In IDLE and DONE, S1 loads v=0.
- Strobes are decoded from S1 and gated by S1.v.
  - src 1, 2, 3 and 4 each drive their matching strobe.
  - src 0, 5, 6 and 7 drive no strobe.
- Illegal src (6 or 7) sets error_o at acceptance. The record still flows through the pipeline and is still checked.
- Check is performed in S3 when S3.v is high. A mismatch occurs if:
  - fetch_v_i != S3.chk_fetch_v, or
  - S3.chk_fetch_v==1 and fetch_pc_i != S3.pc.
  - When chk_fetch_v==0, the PC is not compared.
- On a mismatch:
  - mismatch_o pulses.
  - mismatch_cnt increments, saturating at all-ones.
  - On the first mismatch only, first_bad_pc and first_bad_cycle are captured.
- cycle_cnt increments in RUN and DRAIN when freeze_i is low, and wraps.

## Timing
- Record accepted on edge t: strobe visible in cycle t+1; checked against live signals sampled at edge t+3.
- mismatch_o, and the counter/capture updates it triggers, are registered and visible from edge t+3 to t+4.
- freeze_i stalls every stage, counter and FSM transition. A check is not performed while frozen.
- Reset mid-operation: asynchronous assertion immediately clears all state.
- Reset values:
  - state=IDLE.
  - All pipeline v bits=0.
  - All strobes=0.
  - rec_ready_o=0.
  - mismatch_o=0.
  - All counters=0.
  - first_bad_pc=0 and first_bad_cycle=0.
  - error_o=0 and done_o=0.
- A record with rec_last_i that is accepted while freeze_i is low enters DRAIN on the same edge. No further records are accepted after it.
- A counter at saturation stays at all-ones. The cycle counter wraps.

## Test plan
- Four records are streamed back-to-back with src 1, 5, 4, 2 and PCs 0x80000954, 0x80000958, 0x800007f8, 0x800007fc, all valid. The live PC is mirrored 3 cycles after each acceptance. Required response:
  - Strobes are redirect, none, btb_taken_branch, override_ras on cycles 1–4.
  - mismatch_cnt=0 and done_o is high 3 cycles after the last record.
- The record at 0x80000710 is mismatched by driving a live PC of 0x80000714. Required response:
  - mismatch_o pulses once; mismatch_cnt=1.
  - first_bad_pc=0x80000714 and first_bad_cycle equals the cycle count at that check.
- A record has fetch_v=0 and pc=0x80000998 while the live side drives fetch_v_i=0 and PC 0x12345678 -> no mismatch.
- rec_v_i is dropped for 2 cycles mid-stream -> underflow_cnt=2, no strobes in the corresponding cycles, and no checks 3 cycles later.
- freeze_i is held for 5 cycles with a record in S2 -> state, counters and strobes hold; the check resumes at the correct alignment after release.
- A record with src=7 is accepted -> error_o stays set until reset. Then reset_li is pulsed low in RUN -> all outputs return to their reset values immediately.
